// File: rtl/q2a03_pkg.sv
// Shared Q2A03 types and constants: bus words, DMA state encoding, fixed register addresses.
package q2a03_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PENDING,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    // One system-bus request: what the bus mux presents for a given cycle.
    typedef struct packed {
        word_t addr;
        logic  rdwr;
        byte_t wr_data;
    } bus_req_t;

    localparam word_t       DMA_REG_ADDR    = 16'h4014;
    localparam word_t       OAM_DATA_ADDR   = 16'h2004;
    localparam int unsigned CPU_CLK_DIV     = 12;
    localparam int unsigned OAM_BYTES       = 256;

    // States in which the DMA engine owns the bus and the core is stalled.
    function automatic logic is_stall(input dma_state_t s);
        return (s == ST_HALT) || (s == ST_ALIGN) || (s == ST_READ) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/q2a03_oam_dma_if.sv
// CPU-side and system-side bus bundle around the OAM DMA engine.
interface q2a03_oam_dma_if;
    import q2a03_pkg::*;

    logic  G_phy2;
    word_t cpu_addr;
    logic  cpu_rdwr;
    byte_t cpu_wr_data;
    logic  cpu_ready;
    word_t G_addr;
    logic  G_rdwr;
    byte_t G_wr_data;
    byte_t G_rd_data;
    logic  dma_busy;

    // The DMA engine is the system bus master.
    modport master (
        input  G_phy2,
        input  cpu_addr,
        input  cpu_rdwr,
        input  cpu_wr_data,
        input  G_rd_data,
        output cpu_ready,
        output G_addr,
        output G_rdwr,
        output G_wr_data,
        output dma_busy
    );

    // Core plus memory side of the bundle.
    modport slave (
        output G_phy2,
        output cpu_addr,
        output cpu_rdwr,
        output cpu_wr_data,
        output G_rd_data,
        input  cpu_ready,
        input  G_addr,
        input  G_rdwr,
        input  G_wr_data,
        input  dma_busy
    );

endinterface

// File: rtl/q2a03_cycle_div.sv
// CPU-cycle divider used while the core is stalled: counts G_clock ticks and strobes each cycle end.
module q2a03_cycle_div #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_cyc_end_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_div_cnt;
    logic          w_last;

    assign w_last      = (r_div_cnt == CW'(CLK_DIV - 1));
    assign o_cyc_end_c = i_en & w_last;

    // Holds at zero when disabled so every stall starts on a fresh cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (i_clr || !i_en || w_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/q2a03_oam_dma.sv
// Sprite DMA: snoops writes to the trigger register, stalls the core and copies a 256-byte page
// to the PPU OAM data port; otherwise passes the CPU bus through untouched.
module q2a03_oam_dma
    import q2a03_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CPU_CLK_DIV,
    parameter word_t       DMA_REG  = DMA_REG_ADDR,
    parameter word_t       OAM_DATA = OAM_DATA_ADDR
) (
    input  logic            G_clock,
    input  logic            G_reset,
    q2a03_oam_dma_if.master bus
);

    dma_state_t r_state;
    logic       r_phy2_q;
    logic       r_odd;
    byte_t      r_page;
    byte_t      r_idx;
    byte_t      r_data;
    logic       r_cpu_ready;
    logic       r_dma_busy;

    logic       w_bnd;
    logic       w_stall;
    logic       w_div_clr;
    logic       w_cyc_end;
    logic       w_cpu_cyc;
    logic       w_trigger;
    bus_req_t   w_cpu_req;
    bus_req_t   w_bus_req;

    assign w_bnd     = r_phy2_q & ~bus.G_phy2;
    assign w_stall   = is_stall(r_state);
    assign w_div_clr = (r_state == ST_PENDING) & w_bnd;
    assign w_trigger = w_bnd & (bus.cpu_addr == DMA_REG) & ~bus.cpu_rdwr;
    // A CPU cycle ends on a phy2 fall normally, and on the divider strobe while stalled.
    assign w_cpu_cyc = w_stall ? w_cyc_end : w_bnd;

    q2a03_cycle_div #(
        .CLK_DIV (CLK_DIV)
    ) u_cycle_div (
        .clk         (G_clock),
        .rst         (G_reset),
        .i_clr       (w_div_clr),
        .i_en        (w_stall),
        .o_cyc_end_c (w_cyc_end)
    );

    always_ff @(posedge G_clock or posedge G_reset) begin
        if (G_reset) begin
            r_state     <= ST_IDLE;
            r_phy2_q    <= 1'b0;
            r_odd       <= 1'b0;
            r_page      <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_cpu_ready <= 1'b1;
            r_dma_busy  <= 1'b0;
        end else begin
            r_phy2_q <= bus.G_phy2;
            if (w_cpu_cyc) begin
                r_odd <= ~r_odd;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_page     <= bus.cpu_wr_data;
                        r_idx      <= '0;
                        r_dma_busy <= 1'b1;
                        r_state    <= ST_PENDING;
                    end
                end
                // Let the trigger write finish before taking the bus.
                ST_PENDING: begin
                    if (w_bnd) begin
                        r_cpu_ready <= 1'b0;
                        r_state     <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (w_cyc_end) begin
                        r_state <= r_odd ? ST_ALIGN : ST_READ;
                    end
                end
                ST_ALIGN: begin
                    if (w_cyc_end) begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_cyc_end) begin
                        r_data  <= bus.G_rd_data;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_cyc_end) begin
                        if (r_idx == 8'hFF) begin
                            r_cpu_ready <= 1'b1;
                            r_dma_busy  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= ST_READ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_cpu_req = '{addr: bus.cpu_addr, rdwr: bus.cpu_rdwr, wr_data: bus.cpu_wr_data};

    // System bus mux: pass-through unless the engine owns the bus.
    always_comb begin
        w_bus_req = w_cpu_req;
        unique case (r_state)
            ST_HALT, ST_ALIGN: w_bus_req = '{addr: bus.cpu_addr, rdwr: 1'b1, wr_data: bus.cpu_wr_data};
            ST_READ:           w_bus_req = '{addr: {r_page, r_idx}, rdwr: 1'b1, wr_data: r_data};
            ST_WRITE:          w_bus_req = '{addr: OAM_DATA, rdwr: 1'b0, wr_data: r_data};
            default:           w_bus_req = w_cpu_req;
        endcase
    end

    assign bus.G_addr    = w_bus_req.addr;
    assign bus.G_rdwr    = w_bus_req.rdwr;
    assign bus.G_wr_data = w_bus_req.wr_data;
    assign bus.cpu_ready = r_cpu_ready;
    assign bus.dma_busy  = r_dma_busy;

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Directed bench for q2a03_oam_dma: CPU cycles, a pattern memory and per-tick bus checks during DMA.
module tb_q2a03_oam_dma;
    import q2a03_pkg::*;

    localparam int unsigned CLK_DIV = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pt_bad   = 0;
    int   oam_wr_seen = 0;
    int   ready_low   = 0;

    q2a03_oam_dma_if bus();

    q2a03_oam_dma #(
        .CLK_DIV  (CLK_DIV),
        .DMA_REG  (16'h4014),
        .OAM_DATA (16'h2004)
    ) dut (
        .G_clock (clk),
        .G_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: low byte ^ page ^ 5A, which gives idx ^ A5 on page FF.
    function automatic byte_t mem_byte(input word_t a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign bus.G_rd_data = mem_byte(bus.G_addr);

    task automatic tick_pt();
        @(negedge clk);
        if (bus.cpu_ready !== 1'b1) begin
            ready_low++;
        end else begin
            if (bus.G_addr !== bus.cpu_addr || bus.G_rdwr !== bus.cpu_rdwr ||
                bus.G_wr_data !== bus.cpu_wr_data) pt_bad++;
            if (bus.G_addr === 16'h2004 && bus.G_rdwr === 1'b0) oam_wr_seen++;
        end
    endtask

    // One CPU cycle: phy2 high half then low half; the boundary lands at the start of the low half.
    task automatic cpu_cycle(input word_t a, input logic rd, input byte_t d);
        bus.cpu_addr = a; bus.cpu_rdwr = rd; bus.cpu_wr_data = d; bus.G_phy2 = 1'b1;
        repeat (6) tick_pt();
        bus.G_phy2 = 1'b0;
        repeat (6) tick_pt();
    endtask

    // Trigger write, then start the next CPU cycle whose boundary enters HALT; phy2 then stays frozen.
    task automatic trigger_dma(input byte_t pg);
        cpu_cycle(16'h4014, 1'b0, pg);
        n_checks++;
        if (bus.dma_busy !== 1'b1 || bus.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_flags: busy=%b ready=%b want busy=1 ready=1", bus.dma_busy, bus.cpu_ready);
        end
        bus.cpu_addr = 16'h8000; bus.cpu_rdwr = 1'b1; bus.cpu_wr_data = 8'h00; bus.G_phy2 = 1'b1;
        repeat (6) tick_pt();
        bus.G_phy2 = 1'b0;
    endtask

    task automatic watch_dma(input byte_t pg, input int want_cyc, input int abort_idx,
                             output word_t first_rd, output word_t last_rd, output bit zero_hit);
        int  k, j, ph, m, i, lead;
        int  bad_dummy, bad_rd, bad_wr, bad_busy;
        bit  aborted;
        k = 0; lead = want_cyc - 512;
        bad_dummy = 0; bad_rd = 0; bad_wr = 0; bad_busy = 0; aborted = 1'b0;
        first_rd = 16'hDEAD; last_rd = 16'hDEAD; zero_hit = 1'b0;
        for (int t = 0; t < 8000; t++) begin
            @(negedge clk);
            if (bus.cpu_ready === 1'b1) begin
                if (k > 0) break;
                continue;
            end
            j  = k / int'(CLK_DIV);
            ph = k % int'(CLK_DIV);
            if (bus.dma_busy !== 1'b1) bad_busy++;
            if (bus.G_addr === 16'h0000) zero_hit = 1'b1;
            if (j < lead) begin
                if (bus.G_addr !== 16'h8000 || bus.G_rdwr !== 1'b1) bad_dummy++;
            end else begin
                m = j - lead;
                i = m / 2;
                if (m % 2 == 0) begin
                    if (bus.G_addr !== {pg, 8'(i)} || bus.G_rdwr !== 1'b1) bad_rd++;
                    if (ph == 0) begin
                        if (m == 0) first_rd = bus.G_addr;
                        last_rd = bus.G_addr;
                    end
                end else begin
                    if (bus.G_addr !== 16'h2004 || bus.G_rdwr !== 1'b0 ||
                        bus.G_wr_data !== mem_byte({pg, 8'(i)})) bad_wr++;
                    if (i == abort_idx && ph == 5) begin
                        rst = 1'b1;
                        #1;
                        aborted = 1'b1;
                        break;
                    end
                end
            end
            k++;
        end
        if (abort_idx < 0) begin
            n_checks++;
            if (k != want_cyc * int'(CLK_DIV)) begin
                n_fail++;
                $display("FAIL stall_len page %02h: got %0d ticks want %0d", pg, k, want_cyc * int'(CLK_DIV));
            end
            n_checks++;
            if (bus.dma_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_release page %02h: got %b want 0", pg, bus.dma_busy);
            end
        end else begin
            n_checks++;
            if (!aborted) begin
                n_fail++;
                $display("FAIL abort_reached: write %0d never seen, stall ticks %0d", abort_idx, k);
            end
            n_checks++;
            if (bus.cpu_ready !== 1'b1 || bus.dma_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_async: ready=%b busy=%b want ready=1 busy=0", bus.cpu_ready, bus.dma_busy);
            end
        end
        n_checks++;
        if (bad_dummy != 0) begin
            n_fail++;
            $display("FAIL dummy_cycles page %02h: %0d bad ticks want 0", pg, bad_dummy);
        end
        n_checks++;
        if (bad_rd != 0) begin
            n_fail++;
            $display("FAIL read_seq page %02h: %0d bad ticks want 0", pg, bad_rd);
        end
        n_checks++;
        if (bad_wr != 0) begin
            n_fail++;
            $display("FAIL write_seq page %02h: %0d bad ticks want 0", pg, bad_wr);
        end
        n_checks++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL busy_during page %02h: %0d low ticks want 0", pg, bad_busy);
        end
    endtask

    task automatic test_reset();
        bus.cpu_addr = 16'h1234; bus.cpu_rdwr = 1'b0; bus.cpu_wr_data = 8'h5C; bus.G_phy2 = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.cpu_ready !== 1'b1 || bus.dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b busy=%b want ready=1 busy=0", bus.cpu_ready, bus.dma_busy);
        end
        n_checks++;
        if (bus.G_addr !== 16'h1234 || bus.G_rdwr !== 1'b0 || bus.G_wr_data !== 8'h5C) begin
            n_fail++;
            $display("FAIL reset_passthru: addr=%h rdwr=%b data=%h want 1234/0/5c",
                     bus.G_addr, bus.G_rdwr, bus.G_wr_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_even_parity();
        word_t f, l;
        bit    z;
        trigger_dma(8'h02);
        watch_dma(8'h02, 513, -1, f, l, z);
        n_checks++;
        if (f !== 16'h0200 || l !== 16'h02FF) begin
            n_fail++;
            $display("FAIL even_rd_range: first=%h last=%h want 0200/02ff", f, l);
        end
    endtask

    task automatic test_odd_parity();
        word_t f, l;
        bit    z;
        trigger_dma(8'h02);
        watch_dma(8'h02, 514, -1, f, l, z);
        n_checks++;
        if (f !== 16'h0200) begin
            n_fail++;
            $display("FAIL odd_first_rd: got %h want 0200", f);
        end
    endtask

    task automatic test_page_ff();
        word_t f, l;
        bit    z;
        cpu_cycle(16'h0010, 1'b1, 8'h00);
        trigger_dma(8'hFF);
        watch_dma(8'hFF, 513, -1, f, l, z);
        n_checks++;
        if (l !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL ff_last_rd: got %h want ffff", l);
        end
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_wrap: address 0000 accessed=%b want 0", z);
        end
    endtask

    task automatic test_back_to_back();
        word_t f, l;
        bit    z;
        trigger_dma(8'h03);
        watch_dma(8'h03, 514, -1, f, l, z);
        n_checks++;
        if (f !== 16'h0300) begin
            n_fail++;
            $display("FAIL b2b_first_rd: got %h want 0300", f);
        end
    endtask

    task automatic test_non_trigger();
        pt_bad = 0; ready_low = 0;
        cpu_cycle(16'h4014, 1'b1, 8'h02);
        cpu_cycle(16'h4015, 1'b0, 8'h07);
        cpu_cycle(16'h0000, 1'b1, 8'h00);
        n_checks++;
        if (ready_low != 0 || bus.dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nontrig_idle: ready_low=%0d busy=%b want 0/0", ready_low, bus.dma_busy);
        end
        n_checks++;
        if (pt_bad != 0) begin
            n_fail++;
            $display("FAIL nontrig_passthru: %0d bad ticks want 0", pt_bad);
        end
    endtask

    task automatic test_reset_mid();
        word_t f, l;
        bit    z;
        trigger_dma(8'h05);
        watch_dma(8'h05, 513, 100, f, l, z);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        oam_wr_seen = 0; pt_bad = 0; ready_low = 0;
        for (int c = 0; c < 4; c++) cpu_cycle(16'h0000, 1'b1, 8'h00);
        n_checks++;
        if (oam_wr_seen != 0 || ready_low != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: oam_writes=%0d ready_low=%0d want 0/0", oam_wr_seen, ready_low);
        end
        n_checks++;
        if (pt_bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_passthru: %0d bad ticks want 0", pt_bad);
        end
    endtask

    initial begin
        bus.G_phy2 = 1'b0; bus.cpu_addr = '0; bus.cpu_rdwr = 1'b1; bus.cpu_wr_data = '0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_page_ff();
        test_back_to_back();
        test_non_trigger();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
